max7219_ctrl: RTL and testbench

- Sequencer and arbiter for the MAX7219 display driver on the calculator's three-wire display bus (max_sck/max_cs/max_din).
- After reset it runs the driver's power-up register sequence, then serves two requesters: digit refresh from the calculator fsm and intensity change. It builds and shifts one 16-bit frame at a time.

---
 rtl/max7219_ctrl_if.sv | 9 +
 rtl/max7219_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_max7219_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/max7219_ctrl_if.sv
// Three-wire MAX7219 display bus: serial clock, active-low load/chip-select and serial data.
interface max7219_ctrl_if;
   logic max_sck;
   logic max_cs;
   logic max_din;

   modport master (output max_sck, output max_cs, output max_din);
   modport slave  (input  max_sck, input  max_cs, input  max_din);
endinterface

// File: rtl/max7219_ctrl.sv
// MAX7219 sequencer: runs the power-up register sequence, then arbitrates intensity
// and digit-refresh requests, shifting one 16-bit frame at a time onto the display bus.
module max7219_ctrl #(
   parameter int SCK_DIV  = 4,
   parameter int N_DIGITS = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] digit_code,
   input  logic [7:0]  digit_dp,
   input  logic        update_req,
   input  logic [3:0]  intensity,
   input  logic        intensity_req,
   output logic        busy,
   output logic        init_done,
   max7219_ctrl_if.master bus
);

   localparam int CW = $clog2(2 * SCK_DIV) + 1;

   typedef enum logic [1:0] {INIT, IDLE, INTEN, DIGITS} seq_t;
   typedef enum logic [2:0] {SER_IDLE, CS_SETUP, BIT_LO, BIT_HI, CS_HOLD, GAP} ser_t;

   seq_t        seq;
   ser_t        ser;
   logic [CW-1:0] cnt;
   logic [2:0]  frame_idx;
   logic [3:0]  bit_idx;
   logic [15:0] frame_q;
   logic [31:0] code_snap;
   logic [7:0]  dp_snap;
   logic        upd_pend;
   logic        int_pend;
   logic [15:0] next_frame;
   logic        last_frame;

   wire phase_end = (cnt == CW'(SCK_DIV - 1));
   wire gap_end   = (cnt == CW'(2 * SCK_DIV - 1));

   // Frame contents for the current position in whichever sequence is running.
   always_comb begin
      next_frame = 16'h0000;
      last_frame = 1'b0;
      case (seq)
         INIT: begin
            case (frame_idx)
               3'd0:    next_frame = 16'h0F00;
               3'd1:    next_frame = 16'h09FF;
               3'd2:    next_frame = {8'h0A, 4'h0, intensity};
               3'd3:    next_frame = {8'h0B, 8'(N_DIGITS - 1)};
               default: next_frame = 16'h0C01;
            endcase
            last_frame = (frame_idx == 3'd4);
         end
         INTEN: begin
            next_frame = {8'h0A, 4'h0, intensity};
            last_frame = 1'b1;
         end
         DIGITS: begin
            next_frame = {4'h0, {1'b0, frame_idx} + 4'd1, dp_snap[frame_idx], 3'b000,
                          code_snap[{frame_idx, 2'b00} +: 4]};
            last_frame = (frame_idx == 3'(N_DIGITS - 1));
         end
         default: ;
      endcase
   end

   // Sequencer and serializer share one register block; the sequence advances when
   // max_cs rises, while the GAP state still guarantees the inter-frame high time.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seq         <= INIT;
         ser         <= SER_IDLE;
         cnt         <= '0;
         frame_idx   <= 3'd0;
         bit_idx     <= 4'd0;
         frame_q     <= 16'h0000;
         code_snap   <= 32'h0;
         dp_snap     <= 8'h0;
         upd_pend    <= 1'b0;
         int_pend    <= 1'b0;
         busy        <= 1'b0;
         init_done   <= 1'b0;
         bus.max_cs  <= 1'b1;
         bus.max_sck <= 1'b0;
         bus.max_din <= 1'b0;
      end else begin
         busy <= (seq != IDLE) || upd_pend || int_pend;
         case (ser)
            SER_IDLE: begin
               cnt <= '0;
               if (seq == IDLE) begin
                  if (int_pend) begin
                     seq       <= INTEN;
                     frame_idx <= 3'd0;
                     int_pend  <= 1'b0;
                  end else if (upd_pend) begin
                     seq       <= DIGITS;
                     frame_idx <= 3'd0;
                     upd_pend  <= 1'b0;
                     code_snap <= digit_code;
                     dp_snap   <= digit_dp;
                  end
               end else begin
                  frame_q    <= next_frame;
                  bus.max_cs <= 1'b0;
                  ser        <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               if (phase_end) begin
                  cnt         <= '0;
                  bit_idx     <= 4'd15;
                  bus.max_din <= frame_q[15];
                  ser         <= BIT_LO;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BIT_LO: begin
               if (phase_end) begin
                  cnt         <= '0;
                  bus.max_sck <= 1'b1;
                  ser         <= BIT_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BIT_HI: begin
               if (phase_end) begin
                  cnt         <= '0;
                  bus.max_sck <= 1'b0;
                  if (bit_idx == 4'd0) begin
                     ser <= CS_HOLD;
                  end else begin
                     bit_idx     <= bit_idx - 4'd1;
                     bus.max_din <= frame_q[bit_idx - 4'd1];
                     ser         <= BIT_LO;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CS_HOLD: begin
               if (phase_end) begin
                  cnt         <= '0;
                  bus.max_cs  <= 1'b1;
                  bus.max_din <= 1'b0;
                  ser         <= GAP;
                  if (!last_frame) begin
                     frame_idx <= frame_idx + 3'd1;
                  end else if (seq == INIT) begin
                     init_done <= 1'b1;
                     frame_idx <= 3'd0;
                     if (upd_pend) begin
                        seq       <= DIGITS;
                        upd_pend  <= 1'b0;
                        code_snap <= digit_code;
                        dp_snap   <= digit_dp;
                     end else begin
                        seq <= IDLE;
                     end
                  end else begin
                     seq <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_end) begin
                  cnt <= '0;
                  ser <= SER_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ser <= SER_IDLE;
         endcase
         // A request landing in the same cycle as its flag is cleared must survive.
         if (update_req) upd_pend <= 1'b1;
         if (intensity_req) int_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_max7219_ctrl.sv
// Scoreboard bench for max7219_ctrl: stimulus pushes expected frames, a bus monitor
// decodes frames off the serial pins and pops/compares them.
module tb_max7219_ctrl;

   logic        clock = 1'b0;
   logic        reset, reset2;
   logic [31:0] digit_code, digit_code2;
   logic [7:0]  digit_dp, digit_dp2;
   logic        update_req, update_req2;
   logic [3:0]  intensity, intensity2;
   logic        intensity_req;
   logic        busy, busy2, init_done, init_done2;

   int tests = 0;
   int fails = 0;

   logic [15:0] exp0[$];
   logic [15:0] exp1[$];

   max7219_ctrl_if bus1();
   max7219_ctrl_if bus2();

   max7219_ctrl #(.SCK_DIV(2), .N_DIGITS(8)) dut (
      .clock(clock), .reset(reset), .digit_code(digit_code), .digit_dp(digit_dp),
      .update_req(update_req), .intensity(intensity), .intensity_req(intensity_req),
      .busy(busy), .init_done(init_done), .bus(bus1)
   );

   max7219_ctrl #(.SCK_DIV(1), .N_DIGITS(3)) dut_small (
      .clock(clock), .reset(reset2), .digit_code(digit_code2), .digit_dp(digit_dp2),
      .update_req(update_req2), .intensity(intensity2), .intensity_req(1'b0),
      .busy(busy2), .init_done(init_done2), .bus(bus2)
   );

   always #5 clock = ~clock;

   logic [1:0] sck_v, cs_v, din_v, rst_v;
   assign sck_v = {bus2.max_sck, bus1.max_sck};
   assign cs_v  = {bus2.max_cs,  bus1.max_cs};
   assign din_v = {bus2.max_din, bus1.max_din};
   assign rst_v = {reset2, reset};

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] digit_frame(input int i, input logic [31:0] code,
                                               input logic [7:0] dp);
      return {4'h0, 4'(i + 1), dp[i], 3'b000, code[4*i +: 4]};
   endfunction

   task automatic push_exp(input int k, input logic [15:0] f);
      if (k == 0) exp0.push_back(f);
      else        exp1.push_back(f);
   endtask

   task automatic push_init(input int k, input logic [3:0] inten, input int nd);
      push_exp(k, 16'h0F00);
      push_exp(k, 16'h09FF);
      push_exp(k, {8'h0A, 4'h0, inten});
      push_exp(k, {8'h0B, 8'(nd - 1)});
      push_exp(k, 16'h0C01);
   endtask

   task automatic push_digits(input int k, input logic [31:0] code, input logic [7:0] dp,
                              input int nd);
      for (int i = 0; i < nd; i++) push_exp(k, digit_frame(i, code, dp));
   endtask

   // Bus decoder state, one slot per DUT instance.
   logic        prev_sck[2], prev_cs[2], prev_din[2], proto_err[2];
   logic [15:0] shreg[2];
   int          nbits[2], low_cnt[2], hi_cnt[2], frames_seen[2];

   initial begin
      frames_seen[0] = 0;
      frames_seen[1] = 0;
   end

   task automatic pop_compare(input int k, input logic [15:0] got);
      logic [15:0] want;
      if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
         check_output(k == 0 ? "unexpected_frame_dut" : "unexpected_frame_small",
                      {16'h0, got}, 32'hFFFF_FFFF);
         return;
      end
      want = (k == 0) ? exp0.pop_front() : exp1.pop_front();
      check_output(k == 0 ? "frame_dut" : "frame_small", {16'h0, got}, {16'h0, want});
   endtask

   // Monitor: decodes frames off the pins and checks bus timing rules.
   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         int div;
         div = (k == 0) ? 2 : 1;
         if (rst_v[k]) begin
            prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_din[k] = 1'b0;
            nbits[k] = 0; low_cnt[k] = 0; hi_cnt[k] = 1000; proto_err[k] = 1'b0;
            shreg[k] = 16'h0;
         end else begin
            if (cs_v[k] && sck_v[k]) proto_err[k] = 1'b1;
            if (din_v[k] != prev_din[k] && sck_v[k] && prev_sck[k]) proto_err[k] = 1'b1;
            if (prev_cs[k] && !cs_v[k]) begin
               check_output("cs_gap", {31'h0, hi_cnt[k] >= 2 * div}, 32'h1);
               nbits[k] = 0; low_cnt[k] = 0; shreg[k] = 16'h0;
            end
            if (!cs_v[k]) begin
               low_cnt[k]++;
               if (!prev_sck[k] && sck_v[k]) begin
                  shreg[k] = {shreg[k][14:0], din_v[k]};
                  nbits[k]++;
               end
            end else begin
               hi_cnt[k]++;
            end
            if (!prev_cs[k] && cs_v[k]) begin
               check_output("frame_bits", nbits[k], 16);
               check_output("cs_low_cycles", low_cnt[k], 34 * div);
               check_output("bus_protocol", {31'h0, proto_err[k]}, 32'h0);
               pop_compare(k, shreg[k]);
               frames_seen[k]++;
               hi_cnt[k] = 1;
               proto_err[k] = 1'b0;
            end
            prev_cs[k] = cs_v[k]; prev_sck[k] = sck_v[k]; prev_din[k] = din_v[k];
         end
      end
   end

   task automatic apply_stimulus(input logic upd, input logic inten);
      @(negedge clock);
      update_req    = upd;
      intensity_req = inten;
      @(negedge clock);
      update_req    = 1'b0;
      intensity_req = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int target, cyc;
      target = frames_seen[0] + n;
      cyc = 0;
      while (frames_seen[0] < target && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
      check_output("wait_frames_timeout", {31'h0, frames_seen[0] >= target}, 32'h1);
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      repeat (2) @(negedge clock);
      while ((busy || exp0.size() != 0) && cyc < 20000) begin
         @(negedge clock);
         cyc++;
      end
      check_output("sequence_done", {31'h0, !busy && exp0.size() == 0}, 32'h1);
   endtask

   initial begin
      logic [31:0] code, code2;
      logic [7:0]  dp, dp2;
      int          mode, cyc, busy_low;

      reset = 1'b1; reset2 = 1'b1;
      digit_code = 32'h0; digit_dp = 8'h0; update_req = 1'b0; intensity_req = 1'b0;
      intensity = 4'h7;
      digit_code2 = 32'h0; digit_dp2 = 8'h0; update_req2 = 1'b0;
      intensity2 = 4'($urandom);

      repeat (3) @(negedge clock);
      check_output("reset_cs",        {31'h0, bus1.max_cs},  32'h1);
      check_output("reset_sck",       {31'h0, bus1.max_sck}, 32'h0);
      check_output("reset_din",       {31'h0, bus1.max_din}, 32'h0);
      check_output("reset_busy",      {31'h0, busy},         32'h0);
      check_output("reset_init_done", {31'h0, init_done},    32'h0);

      push_init(0, 4'h7, 8);
      push_init(1, intensity2, 3);
      reset = 1'b0; reset2 = 1'b0;
      @(negedge clock);
      check_output("busy_after_reset", {31'h0, busy}, 32'h1);
      wait_idle();
      check_output("init_done_after_init", {31'h0, init_done}, 32'h1);
      check_output("busy_after_init",      {31'h0, busy},      32'h0);

      // Small instance: scan limit and a three-digit refresh.
      code2 = $urandom; dp2 = 8'($urandom);
      digit_code2 = code2; digit_dp2 = dp2;
      check_output("small_init_done", {31'h0, init_done2}, 32'h1);
      push_digits(1, code2, dp2, 3);
      @(negedge clock); update_req2 = 1'b1;
      @(negedge clock); update_req2 = 1'b0;

      for (int it = 0; it < 10; it++) begin
         mode = (it < 4) ? it : int'($urandom_range(0, 3));
         code = (it == 0) ? 32'h7654_3210 : $urandom;
         dp   = (it == 0) ? 8'h01 : 8'($urandom);
         digit_code = code; digit_dp = dp;
         intensity  = (it == 2) ? 4'hF : 4'($urandom);
         case (mode)
            0: begin
               push_digits(0, code, dp, 8);
               apply_stimulus(1'b1, 1'b0);
               wait_frames(3);
               digit_code = $urandom; digit_dp = 8'($urandom);
            end
            1: begin
               push_exp(0, {8'h0A, 4'h0, intensity});
               apply_stimulus(1'b0, 1'b1);
            end
            2: begin
               push_exp(0, {8'h0A, 4'h0, intensity});
               push_digits(0, code, dp, 8);
               apply_stimulus(1'b1, 1'b1);
            end
            default: begin
               push_digits(0, code, dp, 8);
               apply_stimulus(1'b1, 1'b0);
               wait_frames(2);
               repeat (3) apply_stimulus(1'b1, 1'b0);
               code2 = $urandom; dp2 = 8'($urandom);
               digit_code = code2; digit_dp = dp2;
               push_digits(0, code2, dp2, 8);
            end
         endcase
         wait_idle();
      end

      // Refresh requested during INIT frame 2 follows INIT without dropping busy.
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_output("reinit_init_done_cleared", {31'h0, init_done}, 32'h0);
      intensity = 4'($urandom);
      code = $urandom; dp = 8'($urandom);
      digit_code = code; digit_dp = dp;
      push_init(0, intensity, 8);
      push_digits(0, code, dp, 8);
      reset = 1'b0;
      wait_frames(1);
      apply_stimulus(1'b1, 1'b0);
      cyc = 0;
      while (!init_done && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
      check_output("init_done_rise", {31'h0, init_done}, 32'h1);
      busy_low = 0;
      cyc = 0;
      while (exp0.size() != 0 && cyc < 5000) begin
         if (!busy) busy_low++;
         @(negedge clock);
         cyc++;
      end
      check_output("busy_gap_init_to_digits", busy_low, 0);
      wait_idle();

      // Asynchronous reset mid-frame.
      code = $urandom; dp = 8'($urandom);
      digit_code = code; digit_dp = dp;
      push_digits(0, code, dp, 8);
      apply_stimulus(1'b1, 1'b0);
      wait_frames(1);
      cyc = 0;
      while (nbits[0] != 9 && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
      check_output("reach_bit9", nbits[0], 9);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check_output("async_reset_cs",   {31'h0, bus1.max_cs},  32'h1);
      check_output("async_reset_sck",  {31'h0, bus1.max_sck}, 32'h0);
      check_output("async_reset_busy", {31'h0, busy},         32'h0);
      check_output("async_reset_init", {31'h0, init_done},    32'h0);
      exp0.delete();
      repeat (3) @(negedge clock);
      intensity = 4'($urandom);
      push_init(0, intensity, 8);
      reset = 1'b0;
      wait_frames(2);
      check_output("init_done_mid_reinit", {31'h0, init_done}, 32'h0);
      wait_idle();
      check_output("init_done_after_reinit", {31'h0, init_done}, 32'h1);

      check_output("dut_queue_empty",   exp0.size(), 0);
      check_output("small_queue_empty", exp1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
